// File: rtl/tile_raster_seq.sv
// Raster scanner for one 2^TILE_LOG2 square tile: walks pixel positions, forwards covered ones over a valid/ready handshake.
// Optional ROW_EARLY_EXIT_EN: convex-row early exit (first miss after a hit ends the row).
module tile_raster_seq #(
  parameter int TILE_LOG2 = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [10-TILE_LOG2:0]   tile_x,
  input  logic [10-TILE_LOG2:0]   tile_y,
  output logic [10:0]             x_ps,
  output logic [10:0]             y_ps,
  input  logic                    in_tri,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [10:0]             pix_x,
  output logic [10:0]             pix_y,
  output logic                    busy,
  output logic                    done,
  output logic [2*TILE_LOG2:0]    hit_count
);

  localparam logic [TILE_LOG2-1:0] ONE_T = TILE_LOG2'(1);
  localparam logic [2*TILE_LOG2:0] ONE_H = (2*TILE_LOG2+1)'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [10-TILE_LOG2:0]   r_tx, r_ty;
  logic [TILE_LOG2-1:0]    r_row, r_col;
  logic                    r_pix_valid;
  logic [10:0]             r_pix_x, r_pix_y;
  logic [2*TILE_LOG2:0]    r_hit;
`ifdef ROW_EARLY_EXIT_EN
  logic                    r_row_hit;
`endif

  logic w_adv, w_end_row, w_accept, w_step, w_drain_clr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_drain_clr = 1'b0;
    w_adv       = !r_pix_valid || pix_ready;
`ifdef ROW_EARLY_EXIT_EN
    w_end_row   = (&r_col) || (r_row_hit && !in_tri);
`else
    w_end_row   = &r_col;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (w_adv) begin
          w_step = 1'b1;
          if (w_end_row && (&r_row)) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_adv) begin
          w_drain_clr = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx        <= '0;
      r_ty        <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_hit       <= '0;
`ifdef ROW_EARLY_EXIT_EN
      r_row_hit   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_tx  <= tile_x;
      r_ty  <= tile_y;
      r_row <= '0;
      r_col <= '0;
      r_hit <= '0;
`ifdef ROW_EARLY_EXIT_EN
      r_row_hit <= 1'b0;
`endif
    end else if (w_step) begin
      // The row index wraps back to 0 after the last row; harmless since SCAN ends there.
      if (w_end_row) begin
        r_col <= '0;
        r_row <= r_row + ONE_T;
      end else begin
        r_col <= r_col + ONE_T;
      end
`ifdef ROW_EARLY_EXIT_EN
      if (w_end_row)   r_row_hit <= 1'b0;
      else if (in_tri) r_row_hit <= 1'b1;
`endif
      r_pix_valid <= in_tri;
      if (in_tri) begin
        r_pix_x <= x_ps;
        r_pix_y <= y_ps;
        r_hit   <= r_hit + ONE_H;
      end
    end else if (w_drain_clr) begin
      r_pix_valid <= 1'b0;
    end
  end

  assign x_ps      = {r_tx, r_col};
  assign y_ps      = {r_ty, r_row};
  assign pix_valid = r_pix_valid;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign hit_count = r_hit;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_tile_raster_seq.sv
// Directed bench for tile_raster_seq (TILE_LOG2=5): coverage patterns, stalls, reset mid-scan, held start.
module tb_tile_raster_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  tile_x = '0, tile_y = '0;
  logic [10:0] x_ps, y_ps, pix_x, pix_y;
  logic        in_tri, pix_valid, busy, done;
  logic        pix_ready = 1'b1;
  logic [10:0] hit_count;

  int n_total = 0;
  int n_bad   = 0;
  int mode    = 0;
  int first_x, first_y, last_x, last_y, ord_err;
  int dcyc, npix, frz;

  tile_raster_seq #(.TILE_LOG2(5)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .tile_x(tile_x), .tile_y(tile_y), .x_ps(x_ps), .y_ps(y_ps),
    .in_tri(in_tri), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .done(done),
    .hit_count(hit_count)
  );

  always #5 clock = ~clock;

  function automatic logic cov(input int m, input int col);
    case (m)
      1:       return 1'b1;
      2:       return col == 5;
      3:       return (col >= 3) && (col <= 7);
      default: return 1'b0;
    endcase
  endfunction

  assign in_tri = cov(mode, int'(x_ps[4:0]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Starts a tile and runs until done (or budget); checks transferred pixels against raster order.
  task automatic run_tile(input int tx, input int ty, input int stall_n);
    int cyc = 0;
    int m = 0;
    int stall_left = 0;
    bit seen = 0;
    logic [10:0] fx = '0;
    dcyc = -1; npix = 0; frz = 0; ord_err = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    @(negedge clock);
    tile_x = 6'(tx); tile_y = 6'(ty); start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    while (cyc < 3000 && dcyc < 0) begin
      @(negedge clock);
      cyc++;
      if (stall_left > 0) begin
        if (pix_valid && x_ps == fx && int'(pix_x) == first_x && int'(pix_y) == first_y) frz++;
        stall_left--;
        if (stall_left == 0) pix_ready = 1'b1;
      end else if (pix_valid && !seen && stall_n > 0) begin
        fx = x_ps;
        pix_ready = 1'b0;
        stall_left = stall_n;
      end
      if (pix_valid && !seen) begin
        seen = 1; first_x = int'(pix_x); first_y = int'(pix_y);
      end
      if (pix_valid && pix_ready) begin
        npix++;
        last_x = int'(pix_x); last_y = int'(pix_y);
        while (m < 1024 && !cov(mode, m % 32)) m++;
        if (int'(pix_x) != tx*32 + m % 32 || int'(pix_y) != ty*32 + m / 32) ord_err++;
        m++;
      end
      if (done) dcyc = cyc;
    end
  endtask

  initial begin
    int dn;
    // Reset values
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_hit", hit_count, 0);
    chk("rst_xps", x_ps, 0);
    chk("rst_yps", y_ps, 0);
    chk("rst_pixx", pix_x, 0);
    chk("rst_pixy", pix_y, 0);
    @(negedge clock); reset_n = 1'b1;

    // Full coverage, tile (2,3)
    mode = 1; pix_ready = 1'b1;
    run_tile(2, 3, 0);
    chk("full_npix", npix, 1024);
    chk("full_first_x", first_x, 64);
    chk("full_first_y", first_y, 96);
    chk("full_last_x", last_x, 95);
    chk("full_last_y", last_y, 127);
    chk("full_order", ord_err, 0);
    chk("full_hit", hit_count, 1024);
    chk("full_done_cyc", dcyc, 1026);
    chk("full_busy_at_done", busy, 1);
    @(negedge clock);
    chk("full_busy_after", busy, 0);
    chk("full_done_after", done, 0);
    repeat (5) @(negedge clock);
    chk("full_hit_hold", hit_count, 1024);

    // No coverage
    mode = 0;
    run_tile(1, 1, 0);
    chk("none_npix", npix, 0);
    chk("none_first", first_x, -1);
    chk("none_hit", hit_count, 0);
    chk("none_done_cyc", dcyc, 1026);
    dn = 0;
    repeat (10) begin @(negedge clock); if (done) dn++; end
    chk("none_done_once", dn, 0);
    chk("none_busy_after", busy, 0);

    // Column 5 only, 4-cycle stall on the first pixel
    mode = 2;
    run_tile(0, 0, 4);
    chk("stall_first_x", first_x, 5);
    chk("stall_first_y", first_y, 0);
    chk("stall_frozen", frz, 4);
    chk("stall_npix", npix, 32);
    chk("stall_order", ord_err, 0);
    chk("stall_hit", hit_count, 32);
    chk("stall_done_cyc", dcyc, 1030);

    // Columns 3..7 per row (convex span)
    mode = 3;
    run_tile(4, 5, 0);
    chk("span_npix", npix, 160);
    chk("span_order", ord_err, 0);
    chk("span_hit", hit_count, 160);
`ifdef ROW_EARLY_EXIT_EN
    chk("span_done_cyc", dcyc, 32*9 + 2);
`else
    chk("span_done_cyc", dcyc, 1026);
`endif

    // Reset at cycle 100 of a scan
    mode = 1;
    @(negedge clock);
    tile_x = 6'd2; tile_y = 6'd3; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (100) @(negedge clock);
    chk("mid_xps", x_ps, 67);
    chk("mid_yps", y_ps, 99);
    chk("mid_hit", hit_count, 99);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", pix_valid, 0);
    chk("arst_hit", hit_count, 0);
    chk("arst_xps", x_ps, 0);
    chk("arst_yps", y_ps, 0);
    chk("arst_pixx", pix_x, 0);
    chk("arst_pixy", pix_y, 0);
    @(negedge clock); reset_n = 1'b1;
    dn = 0;
    repeat (50) begin @(negedge clock); if (done || busy) dn++; end
    chk("arst_no_done", dn, 0);
    run_tile(1, 1, 0);
    chk("arst_rerun_hit", hit_count, 1024);
    chk("arst_rerun_done", dcyc, 1026);

    // Start held high through scans and DONE
    begin
      int c = 0, nd = 0, d1 = -1, d2 = -1, b1027 = -1, xhi = -1;
      mode = 0;
      @(negedge clock);
      tile_x = 6'd0; tile_y = 6'd0; start = 1'b1;
      while (c < 2060) begin
        @(negedge clock);
        c++;
        if (c == 500) tile_x = 6'd7;
        if (c == 501) xhi = int'(x_ps[10:5]);
        if (c == 1027) b1027 = int'(busy);
        if (done) begin
          nd++;
          if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
        end
        if (c == 2053) start = 1'b0;
      end
      chk("hold_done1", d1, 1026);
      chk("hold_idle_gap", b1027, 0);
      chk("hold_done2", d2, 2053);
      chk("hold_done_count", nd, 2);
      chk("hold_tile_kept", xhi, 0);
      chk("hold_idle_end", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_raster_seq.md
TILE_RASTER_SEQ -- requirements
Module: tile_raster_seq

Interface
REQ-001 SHALL have parameter TILE_LOG2, default 5: log2 of tile edge in pixels (32x32 tile).
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle request to scan one tile; sampled only in IDLE.
REQ-005 SHALL have port tile_x  input  11-TILE_LOG2  tile column index; captured on accepted start.
REQ-006 SHALL have port tile_y  input  11-TILE_LOG2  tile row index; captured on accepted start.
REQ-007 SHALL have port x_ps  output  11  pixel X to edge-test datapath, {tile_x_q, col}.
REQ-008 SHALL have port y_ps  output  11  pixel Y to edge-test datapath, {tile_y_q, row}.
REQ-009 SHALL have port in_tri  input  1  combinational coverage result for the current x_ps/y_ps, valid in the same cycle.
REQ-010 SHALL have port pix_valid  output  1  covered pixel available.
REQ-011 SHALL have port pix_ready  input  1  downstream accepts pixel when high with pix_valid.
REQ-012 SHALL have port pix_x, pix_y  output  11 each  coordinates of the covered pixel.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of tile.
REQ-015 SHALL have port hit_count  output  2*TILE_LOG2+1  number of covered pixels emitted for the current tile.

Function
REQ-016 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-017 IDLE: start=1 SHALL capture tile_x/tile_y, clear row/col/hit_count, and go to SCAN.
REQ-018 SCAN: advance = !pix_valid || pix_ready; when advance=1, SHALL sample in_tri and step col, wrapping col from 2^TILE_LOG2-1 to 0 with row+1.
REQ-019 SCAN with advance=0 SHALL hold x_ps, y_ps, row and col unchanged (stall).
REQ-020 Sampled in_tri=1 SHALL load pix_x/pix_y with the current x_ps/y_ps, set pix_valid next cycle, and increment hit_count.
REQ-021 Sampled in_tri=0 with pix_ready=1 SHALL clear pix_valid next cycle.
REQ-022 pix_valid, pix_x and pix_y SHALL stay stable while pix_valid=1 and pix_ready=0.
REQ-023 Advancing at the last position (row=col=max) SHALL go to DRAIN.
REQ-024 DRAIN SHALL wait until pix_valid=0 or pix_ready=1, then go to DONE.
REQ-025 DONE SHALL assert done for exactly one cycle, then go to IDLE; a start in DONE SHALL be ignored.
REQ-026 start while busy=1 SHALL be ignored without side effects.
REQ-027 Unstalled throughput SHALL be one position per cycle; a full tile takes 2^(2*TILE_LOG2) SCAN cycles, then DRAIN, then DONE.
REQ-028 hit_count SHALL hold its final value through IDLE until the next accepted start.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, with pix_valid=0, done=0, busy=0, hit_count=0, x_ps=0, y_ps=0, pix_x=0, pix_y=0, and row=col=0.
REQ-030 reset mid-scan SHALL discard the tile; no done pulse SHALL be issued.

Configuration
REQ-031 Macro ROW_EARLY_EXIT_EN SHALL control convex-row early exit.
REQ-032 With ROW_EARLY_EXIT_EN defined: after a hit in the current row, the first sampled miss SHALL end the row (col->0, row+1, or DRAIN if on the last row); that miss emits no pixel.
REQ-033 Without ROW_EARLY_EXIT_EN: every column of every row SHALL be sampled.

Verification
REQ-034 in_tri tied 1, pix_ready tied 1, tile_x=2, tile_y=3, start -> 1024 pixels, first pix (64,96), last (95,127), hit_count=1024, done 1026 cycles after start.
REQ-035 in_tri tied 0 -> pix_valid never set, hit_count=0, done pulses once, busy drops with done.
REQ-036 in_tri=1 only at col 5, pix_ready low 4 cycles on the first pixel -> x_ps frozen for 4 cycles, pix (5,0) stable, no pixel lost, hit_count=32.
REQ-037 in_tri=1 for col 3..7 of each row with ROW_EARLY_EXIT_EN -> row ends at col 8, scan takes 32*9 cycles; without macro it takes 1024 cycles; both give hit_count=160.
REQ-038 reset_n pulsed low at cycle 100 of a scan -> all outputs at reset values immediately, no done pulse; a new start then completes normally.
REQ-039 start held high through the scan and the DONE cycle -> second scan begins only after IDLE is re-entered; done pulses exactly once per scan.
